// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: access-size encodings, the access FSM
// states and the alignment rule.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // The unused size code 2'b11 is treated like a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data replication and byte enables on the way out,
// lane select plus sign/zero extension on the way back.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_wdata = i_wdata;
        o_be    = 4'b1111;
        case (i_size)
            SZ_BYTE: begin
                o_wdata = {4{i_wdata[7:0]}};
                o_be    = 4'b0001 << i_addr_lo;
            end
            SZ_HALF: begin
                o_wdata = {2{i_wdata[15:0]}};
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: ;
        endcase
    end

    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_rdata = i_rdata;
        case (i_size)
            SZ_BYTE: o_rdata = i_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: o_rdata = i_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// EX/MEM pipeline register with a variable-latency data-memory handshake.
//   state  | meaning
//   IDLE   | register holds a non-memory, empty or misaligned op
//   ACCESS | request held on the bus, upstream frozen, waiting for ack
//   DONE   | load/store (or bus error) result presented to WB
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EX_Valid,
    input  logic              EX_MemRead,
    input  logic              EX_MemWrite,
    input  logic [1:0]        EX_MemSize,
    input  logic              EX_LoadUnsigned,
    input  logic [31:0]       EX_ALUResult,
    input  logic [31:0]       EX_WriteData,
    input  logic              EX_RegWrite,
    input  logic [4:0]        EX_WriteReg,
    input  logic              EX_MemtoReg,
    output logic              MEM_Stall,
    output logic              DMem_Req,
    output logic              DMem_We,
    output logic [ADDR_W-1:0] DMem_Addr,
    output logic [31:0]       DMem_WData,
    output logic [3:0]        DMem_BE,
    input  logic              DMem_Ack,
    input  logic [31:0]       DMem_RData,
    output logic              MEM_Valid,
    output logic [31:0]       MEM_ALUResult,
    output logic [31:0]       MEM_ReadData,
    output logic              MEM_RegWrite,
    output logic [4:0]        MEM_WriteReg,
    output logic              MEM_MemtoReg,
    output logic              MEM_AddrExc,
    output logic              MEM_BusErr
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            r_state;
    logic              r_valid;
    logic              r_read;
    logic              r_write;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [31:0]       r_alu;
    logic [31:0]       r_wdata;
    logic              r_regwrite;
    logic [4:0]        r_wreg;
    logic              r_memtoreg;
    logic              r_addr_exc;
    logic              r_bus_err;
    logic [31:0]       r_rdata;
    logic [TMR_W-1:0]  r_tmr;

    logic              w_access;
    logic              w_memop;
    logic              w_misalign;
    logic [31:0]       w_st_wdata;
    logic [3:0]        w_st_be;
    logic [31:0]       w_ld_data;

    assign w_access   = (r_state == ACCESS);
    assign w_memop    = EX_Valid & (EX_MemRead | EX_MemWrite);
    assign w_misalign = w_memop & is_misaligned(EX_MemSize, EX_ALUResult[1:0]);

    mem_lane_align u_align (
        .i_size     (r_size),
        .i_addr_lo  (r_alu[1:0]),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .i_rdata    (DMem_RData),
        .o_wdata    (w_st_wdata),
        .o_be       (w_st_be),
        .o_rdata    (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_valid    <= 1'b0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_alu      <= '0;
            r_wdata    <= '0;
            r_regwrite <= 1'b0;
            r_wreg     <= '0;
            r_memtoreg <= 1'b0;
            r_addr_exc <= 1'b0;
            r_bus_err  <= 1'b0;
            r_rdata    <= '0;
            r_tmr      <= '0;
        end else if (r_state == ACCESS) begin
            // Ack wins over a timeout expiring in the same cycle.
            if (DMem_Ack) begin
                r_rdata <= r_read ? w_ld_data : 32'b0;
                r_state <= DONE;
            end else if ((TIMEOUT != 0) && (r_tmr == '0)) begin
                r_bus_err <= 1'b1;
                r_state   <= DONE;
            end else begin
                r_tmr <= r_tmr - 1'b1;
            end
        end else begin
            r_valid    <= EX_Valid;
            r_read     <= EX_MemRead;
            r_write    <= EX_MemWrite;
            r_size     <= EX_MemSize;
            r_unsigned <= EX_LoadUnsigned;
            r_alu      <= EX_ALUResult;
            r_wdata    <= EX_WriteData;
            r_regwrite <= EX_RegWrite;
            r_wreg     <= EX_WriteReg;
            r_memtoreg <= EX_MemtoReg;
            r_addr_exc <= w_misalign;
            r_bus_err  <= 1'b0;
            r_rdata    <= '0;
            r_tmr      <= TMR_LOAD;
            r_state    <= (w_memop && !w_misalign) ? ACCESS : IDLE;
        end
    end

    assign MEM_Stall     = w_access;
    assign DMem_Req      = w_access;
    assign DMem_We       = w_access & r_write;
    assign DMem_Addr     = {r_alu[ADDR_W-1:2], 2'b00};
    assign DMem_WData    = w_st_wdata;
    assign DMem_BE       = r_write ? w_st_be : 4'b1111;

    assign MEM_Valid     = (r_state == DONE) | ((r_state == IDLE) & r_valid);
    assign MEM_ALUResult = r_alu;
    assign MEM_ReadData  = r_rdata;
    assign MEM_RegWrite  = r_regwrite & MEM_Valid & ~r_addr_exc & ~r_bus_err;
    assign MEM_WriteReg  = r_wreg;
    assign MEM_MemtoReg  = r_memtoreg;
    assign MEM_AddrExc   = r_addr_exc;
    assign MEM_BusErr    = r_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus a random
// op stream checked against a behavioural model of the MEM stage.
module tb_mem_access_stage;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        EX_Valid, EX_MemRead, EX_MemWrite, EX_LoadUnsigned;
    logic [1:0]  EX_MemSize;
    logic [31:0] EX_ALUResult, EX_WriteData;
    logic        EX_RegWrite, EX_MemtoReg;
    logic [4:0]  EX_WriteReg;
    logic        MEM_Stall, DMem_Req, DMem_We, DMem_Ack;
    logic [31:0] DMem_Addr, DMem_WData, DMem_RData;
    logic [3:0]  DMem_BE;
    logic        MEM_Valid, MEM_RegWrite, MEM_MemtoReg, MEM_AddrExc, MEM_BusErr;
    logic [31:0] MEM_ALUResult, MEM_ReadData;
    logic [4:0]  MEM_WriteReg;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .EX_Valid(EX_Valid), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
        .EX_MemSize(EX_MemSize), .EX_LoadUnsigned(EX_LoadUnsigned),
        .EX_ALUResult(EX_ALUResult), .EX_WriteData(EX_WriteData),
        .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg), .EX_MemtoReg(EX_MemtoReg),
        .MEM_Stall(MEM_Stall), .DMem_Req(DMem_Req), .DMem_We(DMem_We),
        .DMem_Addr(DMem_Addr), .DMem_WData(DMem_WData), .DMem_BE(DMem_BE),
        .DMem_Ack(DMem_Ack), .DMem_RData(DMem_RData),
        .MEM_Valid(MEM_Valid), .MEM_ALUResult(MEM_ALUResult), .MEM_ReadData(MEM_ReadData),
        .MEM_RegWrite(MEM_RegWrite), .MEM_WriteReg(MEM_WriteReg), .MEM_MemtoReg(MEM_MemtoReg),
        .MEM_AddrExc(MEM_AddrExc), .MEM_BusErr(MEM_BusErr)
    );

    // ---------------- reference model ----------------
    function automatic logic m_misaligned(logic [1:0] sz, logic [31:0] a);
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_wdata(logic [1:0] sz, logic [31:0] d);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [3:0] m_be(logic wr, logic [1:0] sz, logic [31:0] a);
        int unsigned lane;
        lane = a % 4;
        if (!wr || sz == 2'd2) return 4'hF;
        if (sz == 2'd0) return 4'(1 << lane);
        return (lane >= 2) ? 4'hC : 4'h3;
    endfunction

    function automatic logic [31:0] m_load(logic [1:0] sz, logic uns, logic [31:0] a, logic [31:0] r);
        int unsigned lane;
        logic [31:0] v;
        lane = a % 4;
        if (sz == 2'd0) begin
            v = (r >> (8 * lane)) & 32'hFF;
            if (!uns && v >= 128) v = v - 256;
            return v;
        end
        if (sz == 2'd1) begin
            v = (r >> (16 * (lane / 2))) & 32'hFFFF;
            if (!uns && v >= 32768) v = v - 65536;
            return v;
        end
        return r;
    endfunction

    // Drives one EX op at a negedge, runs it through the stage and checks every
    // cycle until the stage can accept the next op. Returns at that negedge.
    task automatic run_op(input string tag, input logic v, input logic rd, input logic wr,
                          input logic [1:0] sz, input logic uns, input logic [31:0] a,
                          input logic [31:0] d, input logic rw, input logic [4:0] wreg,
                          input logic m2r, input int ack_dly, input logic [31:0] rdat);
        logic        memop, mis, tmo;
        int          n_acc;
        logic [71:0] got_a, exp_a;
        logic [75:0] got, exp;
        logic [31:0] exp_rd;
        memop = v & (rd | wr);
        mis   = memop & m_misaligned(sz, a);
        tmo   = (ack_dly >= TO);
        n_acc = tmo ? TO : ack_dly + 1;

        EX_Valid = v; EX_MemRead = rd; EX_MemWrite = wr; EX_MemSize = sz;
        EX_LoadUnsigned = uns; EX_ALUResult = a; EX_WriteData = d;
        EX_RegWrite = rw; EX_WriteReg = wreg; EX_MemtoReg = m2r;
        DMem_Ack = 1'($urandom_range(0, 1));   // stray ack outside ACCESS
        DMem_RData = $urandom;
        @(posedge clk); @(negedge clk);
        DMem_Ack = 1'b0;

        if (memop && !mis) begin
            for (int k = 0; k < n_acc; k++) begin
                got_a = {DMem_Req, MEM_Stall, MEM_Valid, DMem_We, DMem_BE, DMem_Addr,
                         (wr ? DMem_WData : 32'h0)};
                exp_a = {1'b1, 1'b1, 1'b0, wr, m_be(wr, sz, a), a & 32'hFFFFFFFC,
                         (wr ? m_wdata(sz, d) : 32'h0)};
                n_total++;
                if (got_a !== exp_a)
                    $display("FAIL %s access cyc%0d: got %h want %h", tag, k, got_a, exp_a);
                else
                    n_pass++;
                // scramble EX inputs while stalled; none of it may be captured
                EX_Valid = 1'($urandom); EX_MemRead = 1'($urandom); EX_MemWrite = 1'($urandom);
                EX_MemSize = 2'($urandom); EX_ALUResult = $urandom; EX_WriteData = $urandom;
                EX_RegWrite = 1'($urandom); EX_WriteReg = 5'($urandom); EX_MemtoReg = 1'($urandom);
                DMem_Ack = (k == ack_dly);
                DMem_RData = rdat;
                @(posedge clk); @(negedge clk);
            end
            DMem_Ack = 1'b0;
            exp_rd = (tmo || !rd) ? 32'h0 : m_load(sz, uns, a, rdat);
            exp = {1'b1, 1'b0, 1'b0, tmo, 1'b0, rw & !tmo, m2r, wreg, a, exp_rd};
        end else begin
            exp = {v, 1'b0, 1'b0, 1'b0, mis, rw & v & !mis, m2r, wreg, a, 32'h0};
        end
        got = {MEM_Valid, MEM_Stall, DMem_Req, MEM_BusErr, MEM_AddrExc, MEM_RegWrite,
               MEM_MemtoReg, MEM_WriteReg, MEM_ALUResult, MEM_ReadData};
        n_total++;
        if (got !== exp)
            $display("FAIL %s result: got %h want %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic drive_bubble();
        EX_Valid = 0; EX_MemRead = 0; EX_MemWrite = 0; EX_MemSize = 0; EX_LoadUnsigned = 0;
        EX_ALUResult = 0; EX_WriteData = 0; EX_RegWrite = 0; EX_WriteReg = 0; EX_MemtoReg = 0;
        DMem_Ack = 0; DMem_RData = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [78:0] got;
        rst = 1'b1;
        drive_bubble();
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = {MEM_Valid, MEM_Stall, DMem_Req, DMem_We, MEM_BusErr, MEM_AddrExc, MEM_RegWrite,
               MEM_MemtoReg, MEM_WriteReg, MEM_ALUResult, MEM_ReadData};
        n_total++;
        if (got !== 79'h0) $display("FAIL reset_state: got %h want 0", got);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        got = {MEM_Valid, MEM_Stall, DMem_Req, DMem_We, MEM_BusErr, MEM_AddrExc, MEM_RegWrite,
               MEM_MemtoReg, MEM_WriteReg, MEM_ALUResult, MEM_ReadData};
        n_total++;
        if (got !== 79'h0) $display("FAIL reset_bubble: got %h want 0", got);
        else n_pass++;
    endtask

    task automatic test_store_word();
        run_op("sw_deadbeef", 1, 0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 0, 5'd0, 0, 2, 32'h0);
    endtask

    task automatic test_store_byte();
        run_op("sb_a5", 1, 0, 1, 2'd0, 0, 32'h203, 32'h000000A5, 0, 5'd0, 0, 0, 32'h0);
        run_op("sh_hi", 1, 0, 1, 2'd1, 0, 32'h206, 32'h1234BEEF, 0, 5'd0, 0, 1, 32'h0);
    endtask

    task automatic test_loads();
        run_op("lb", 1, 1, 0, 2'd0, 0, 32'h202, 32'h0, 1, 5'd8, 1, 0, 32'h1280FF00);
        n_total++;
        if (MEM_ReadData !== 32'hFFFFFF80) $display("FAIL lb_value: got %h want FFFFFF80", MEM_ReadData);
        else n_pass++;
        run_op("lbu", 1, 1, 0, 2'd0, 1, 32'h202, 32'h0, 1, 5'd9, 1, 0, 32'h1280FF00);
        n_total++;
        if (MEM_ReadData !== 32'h00000080) $display("FAIL lbu_value: got %h want 00000080", MEM_ReadData);
        else n_pass++;
        run_op("lhu", 1, 1, 0, 2'd1, 1, 32'h202, 32'h0, 1, 5'd10, 1, 0, 32'h1280FF00);
        n_total++;
        if (MEM_ReadData !== 32'h00001280) $display("FAIL lhu_value: got %h want 00001280", MEM_ReadData);
        else n_pass++;
        run_op("lh_neg", 1, 1, 0, 2'd1, 0, 32'h100, 32'h0, 1, 5'd11, 1, 3, 32'h0000A001);
    endtask

    task automatic test_misaligned();
        run_op("lw_misalign", 1, 1, 0, 2'd2, 0, 32'h102, 32'h0, 1, 5'd4, 1, 0, 32'h0);
        run_op("nop_after_exc", 1, 0, 0, 2'd0, 0, 32'h55, 32'h0, 1, 5'd5, 0, 0, 32'h0);
        run_op("sh_misalign", 1, 0, 1, 2'd1, 0, 32'h301, 32'h0, 0, 5'd0, 0, 0, 32'h0);
    endtask

    task automatic test_timeout();
        run_op("lw_timeout", 1, 1, 0, 2'd2, 0, 32'h400, 32'h0, 1, 5'd12, 1, TO, 32'h0);
        run_op("after_timeout", 1, 0, 0, 2'd0, 0, 32'h77, 32'h0, 1, 5'd13, 0, 0, 32'h0);
    endtask

    task automatic test_reset_in_access();
        logic [78:0] got;
        logic [75:0] got2, exp2;
        drive_bubble();
        EX_Valid = 1; EX_MemRead = 1; EX_MemSize = 2'd2; EX_ALUResult = 32'h100;
        EX_RegWrite = 1; EX_WriteReg = 5'd3; EX_MemtoReg = 1;
        @(posedge clk); @(negedge clk);
        drive_bubble();
        @(posedge clk); @(negedge clk);
        n_total++;
        if (DMem_Req !== 1'b1) $display("FAIL rst_acc_pre: Req got %b want 1", DMem_Req);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        got = {MEM_Valid, MEM_Stall, DMem_Req, DMem_We, MEM_BusErr, MEM_AddrExc, MEM_RegWrite,
               MEM_MemtoReg, MEM_WriteReg, MEM_ALUResult, MEM_ReadData};
        n_total++;
        if (got !== 79'h0) $display("FAIL rst_acc_clear: got %h want 0", got);
        else n_pass++;
        rst = 1'b0;
        EX_Valid = 1; EX_RegWrite = 1; EX_WriteReg = 5'd7; EX_ALUResult = 32'h1234;
        DMem_Ack = 1'b1; DMem_RData = 32'hCAFEF00D;
        @(posedge clk); @(negedge clk);
        DMem_Ack = 1'b0;
        got2 = {MEM_Valid, MEM_Stall, DMem_Req, MEM_BusErr, MEM_AddrExc, MEM_RegWrite,
                MEM_MemtoReg, MEM_WriteReg, MEM_ALUResult, MEM_ReadData};
        exp2 = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 32'h1234, 32'h0};
        n_total++;
        if (got2 !== exp2) $display("FAIL rst_acc_add: got %h want %h", got2, exp2);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic        v, rd, wr, uns, rw, m2r;
            logic [1:0]  sz;
            logic [31:0] a;
            int          kind, dly;
            v    = ($urandom_range(0, 9) != 0);
            kind = $urandom_range(0, 2);
            rd   = (kind == 1);
            wr   = (kind == 2);
            sz   = 2'($urandom_range(0, 2));
            uns  = 1'($urandom);
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a = (sz == 2'd2) ? (a & ~32'h3) : (sz == 2'd1) ? (a & ~32'h1) : a;
            rw   = wr ? 1'b0 : 1'($urandom);
            m2r  = rd;
            dly  = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 4);
            run_op($sformatf("rand%0d", i), v, rd, wr, sz, uns, a, $urandom, rw,
                   5'($urandom), m2r, dly, $urandom);
        end
        drive_bubble();
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_byte();
        test_loads();
        test_misaligned();
        test_timeout();
        test_reset_in_access();
        test_random();
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- EX/MEM pipeline register plus data-memory access controller for the 5-stage MIPS pipeline.
- Captures the EX-stage store data (EX_WriteData, produced by the store-data forwarding mux) along with address and control.
- Drives a variable-latency data-memory handshake and stalls upstream until the access completes.
- Returns aligned, extended load data. MEM_ReadData feeds both WB and the EX forwarding path.

Parameters:
- ADDR_W, 32, data-memory byte address width.
- TIMEOUT, 16, maximum cycles waiting for DMem_Ack before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- EX_Valid  in  1  EX holds a real instruction
- EX_MemRead  in  1  load
- EX_MemWrite  in  1  store
- EX_MemSize  in  2  00 byte, 01 half, 10 word
- EX_LoadUnsigned  in  1  zero-extend load (lbu/lhu)
- EX_ALUResult  in  32  effective address / ALU result
- EX_WriteData  in  32  store data after forwarding
- EX_RegWrite  in  1  writes a register
- EX_WriteReg  in  5  destination register
- EX_MemtoReg  in  1  WB selects memory data
- MEM_Stall  out  1  freeze PC/IF/ID/EX this cycle
- DMem_Req  out  1  access request
- DMem_We  out  1  write
- DMem_Addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
- DMem_WData  out  32  lane-replicated store data
- DMem_BE  out  4  byte enables
- DMem_Ack  in  1  access complete; DMem_RData valid this cycle
- DMem_RData  in  32  read word
- MEM_Valid  out  1  MEM outputs valid for WB this cycle
- MEM_ALUResult  out  32  registered ALU result
- MEM_ReadData  out  32  aligned, extended load data
- MEM_RegWrite  out  1  gated register write
- MEM_WriteReg  out  5  destination register
- MEM_MemtoReg  out  1  registered MemtoReg
- MEM_AddrExc  out  1  misaligned access, one cycle
- MEM_BusErr  out  1  ack timeout, one cycle

Behaviour:
- All registered outputs and state reset to 0 / IDLE. Reset has priority over every other event.
- Reset during ACCESS: DMem_Req is 0 in the cycle after the reset edge, and any later DMem_Ack is ignored.
- States:
  - IDLE: register holds a non-memory or empty op.
  - ACCESS: Req asserted, waiting for ack.
  - DONE: load/store result presented.
- Capture: when MEM_Stall=0, every edge loads the EX fields into the register.
  - Captured memory op with aligned address: next state ACCESS.
  - Otherwise: next state IDLE.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
  - No request is issued.
  - MEM_AddrExc=1 and MEM_RegWrite=0 for that one cycle; MEM_Valid=1; state stays IDLE.
- ACCESS:
  - DMem_Req=1 and MEM_Stall=1; address, WData and BE are held stable. MEM_Valid=0.
  - On DMem_Ack=1: the formatted RData is registered into MEM_ReadData; next state DONE.
  - Minimum store/load occupancy: capture + 1 ACCESS cycle + DONE.
- DONE: MEM_Valid=1, MEM_Stall=0, so the next EX op is captured on the same edge.
- IDLE: MEM_Valid = captured EX_Valid.
- MEM_RegWrite = registered RegWrite & MEM_Valid & !MEM_AddrExc & !MEM_BusErr.
- Store formatting:
  - byte: WData={4{d[7:0]}}, BE=4'b0001<<addr[1:0]
  - half: WData={2{d[15:0]}}, BE = addr[1] ? 1100 : 0011
  - word: WData=d, BE=1111
  - Reads drive BE=1111 and We=0.
- Load extraction: select the byte/half lane by addr[1:0], then sign- or zero-extend per EX_LoadUnsigned.
- Non-load ops: MEM_ReadData=0.
- Timeout: a counter runs in ACCESS. If it reaches TIMEOUT without ack:
  - Drop Req and go to DONE.
  - MEM_BusErr=1 for that cycle, with MEM_ReadData=0.
- EX_Valid=0, or neither Read nor Write asserted: never requests memory.
- Ack while not in ACCESS is ignored.

Decomposition:
- Shared package (mem_pkg):
  - MemSize encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - State enum: IDLE, ACCESS, DONE.
  - Misalignment check function.
- Sub-module mem_lane_align: combinational store replication / BE generation and load lane extract with extension.

Test Plan:
- sw 0xDEADBEEF to 0x100, ack after 3 cycles -> Req=1, We=1, BE=1111, Addr=0x100, Stall high 3 cycles, then MEM_Valid=1 in DONE.
- sb 0x000000A5 to 0x203 -> WData=0xA5A5A5A5, BE=1000, Addr=0x200.
- lb from 0x202 with RData=0x1280FF00, ack immediate -> MEM_ReadData=0xFFFFFF80; lbu -> 0x00000080; lhu from 0x202 -> 0x00001280.
- lw at 0x102 -> no Req, MEM_AddrExc=1 one cycle, MEM_RegWrite=0, Stall=0.
- lw with no ack, TIMEOUT=16 -> Req high 16 cycles, then MEM_BusErr=1, Req=0, MEM_ReadData=0, pipeline resumes.
- rst asserted in cycle 2 of ACCESS -> next cycle Req=0, Stall=0, all outputs 0; late ack ignored; following add captured normally with MEM_Valid=1.
